// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write-side slave: width defaults, burst
// encodings, response codes and the slave FSM state type.
package axi_pkg;

    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_LEN_BITS  = 8;
    localparam int DEF_SIZE_BITS = 3;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address stepper plus burst legality check.
// Written without any write-side assumptions so a read-side slave can reuse it.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int SIZE_BITS = DEF_SIZE_BITS
) (
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [SIZE_BITS-1:0] size,
    input  logic [1:0]           burst,
    output logic [ADDR_BITS-1:0] next_addr,
    output logic                 illegal
);

    localparam int MAX_SIZE = $clog2(DATA_BITS / 8);

    logic [ADDR_BITS-1:0] one_s;
    logic [ADDR_BITS-1:0] step_s;
    logic [ADDR_BITS-1:0] bsize_s;
    logic [ADDR_BITS-1:0] wrap_mask_s;
    logic [ADDR_BITS-1:0] incr_s;
    logic                 size_bad_s;
    logic                 wrap_len_ok_s;
    logic                 misaligned_s;

    assign one_s       = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    assign step_s      = one_s << size;
    // Total bytes covered by a wrapping burst; always a power of two when legal.
    assign bsize_s     = (ADDR_BITS'(len) + one_s) << size;
    assign wrap_mask_s = bsize_s - one_s;
    assign incr_s      = addr + step_s;

    assign size_bad_s    = (size > SIZE_BITS'(MAX_SIZE));
    assign wrap_len_ok_s = (len == LEN_BITS'(4'd1))  || (len == LEN_BITS'(4'd3)) ||
                           (len == LEN_BITS'(4'd7))  || (len == LEN_BITS'(4'd15));
    assign misaligned_s  = |(addr & (step_s - one_s));

    // Next beat address by burst type; reserved bursts hold the address.
    always_comb begin
        next_addr = addr;
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_s;
            WRAP:    next_addr = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
            default: next_addr = addr;
        endcase
    end

    // Burst legality: oversize beats, reserved type, or a malformed wrap.
    always_comb begin
        illegal = size_bad_s;
        if (burst == RSVD) begin
            illegal = 1'b1;
        end else if (burst == WRAP) begin
            illegal = size_bad_s | ~wrap_len_ok_s | misaligned_s;
        end else begin
            illegal = size_bad_s;
        end
    end

endmodule

// File: rtl/axi_slave_wr.sv
// AXI write-side slave with word-addressed internal memory and a registered
// debug read port. One burst in flight at a time, one B response per burst.
// Optional macro AXI_SLV_WR_STALL_EN: LFSR-driven w_ready back-pressure in DATA.
module axi_slave_wr
    import axi_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int SIZE_BITS = DEF_SIZE_BITS,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [ADDR_BITS-1:0]         aw_addr,
    input  logic [LEN_BITS-1:0]          aw_len,
    input  logic [SIZE_BITS-1:0]         aw_size,
    input  logic [1:0]                   aw_burst,
    input  logic [3:0]                   aw_cache,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [DATA_BITS-1:0]         w_data,
    input  logic [DATA_BITS/8-1:0]       w_strb,
    input  logic                         w_last,
    output logic                         b_valid,
    input  logic                         b_ready,
    output logic [1:0]                   b_resp,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_BITS-1:0]         dbg_rdata
);

    localparam int STRB_BITS  = DATA_BITS / 8;
    localparam int LANE_SHIFT = $clog2(STRB_BITS);
    localparam int IDX_BITS   = $clog2(MEM_DEPTH);

    state_t                 state_r;
    state_t                 next_state_s;

    logic [ADDR_BITS-1:0]   addr_r;
    logic [LEN_BITS-1:0]    len_r;
    logic [SIZE_BITS-1:0]   size_r;
    logic [1:0]             burst_r;
    logic [LEN_BITS-1:0]    beat_cnt_r;
    logic                   err_r;
    logic                   cap_err_r;
    logic                   err_nxt_s;

    logic [ADDR_BITS-1:0]   gen_addr_s;
    logic [LEN_BITS-1:0]    gen_len_s;
    logic [SIZE_BITS-1:0]   gen_size_s;
    logic [1:0]             gen_burst_s;
    logic [ADDR_BITS-1:0]   next_addr_s;
    logic                   illegal_s;

    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   b_hs_s;
    logic                   last_cnt_s;
    logic [ADDR_BITS-1:0]   word_addr_s;
    logic [IDX_BITS-1:0]    idx_s;
    logic                   oob_s;
    logic                   mem_we_s;
    logic                   stall_ok_s;

    logic                   aw_ready_r;
    logic                   w_ready_r;
    logic                   b_valid_r;
    logic [1:0]             b_resp_r;
    logic                   aw_ready_nxt_s;
    logic                   w_ready_nxt_s;
    logic                   b_valid_nxt_s;
    logic [1:0]             b_resp_nxt_s;

    logic [DATA_BITS-1:0]   mem_r [MEM_DEPTH];
    logic [DATA_BITS-1:0]   dbg_rdata_r;

    // Cache attributes are accepted on the bus but have no effect here.
    logic                   unused_s;
    assign unused_s = ^aw_cache;

    assign aw_hs_s     = (state_r == IDLE) & aw_valid & aw_ready_r;
    assign w_hs_s      = (state_r == DATA) & w_valid & w_ready_r;
    assign b_hs_s      = (state_r == RESP) & b_valid_r & b_ready;
    assign last_cnt_s  = (beat_cnt_r == len_r);
    assign word_addr_s = addr_r >> LANE_SHIFT;
    assign idx_s       = word_addr_s[IDX_BITS-1:0];
    assign oob_s       = (word_addr_s >= ADDR_BITS'(MEM_DEPTH));
    // Errors detected at capture kill every beat; out-of-range kills just that beat.
    assign mem_we_s    = w_hs_s & ~oob_s & ~cap_err_r & ~areset;

    // Feed the generator the incoming AW fields while idle (legality check at
    // capture) and the captured burst while walking beats.
    always_comb begin
        gen_addr_s  = addr_r;
        gen_len_s   = len_r;
        gen_size_s  = size_r;
        gen_burst_s = burst_r;
        if (state_r == IDLE) begin
            gen_addr_s  = aw_addr;
            gen_len_s   = aw_len;
            gen_size_s  = aw_size;
            gen_burst_s = aw_burst;
        end else begin
            gen_addr_s  = addr_r;
            gen_len_s   = len_r;
            gen_size_s  = size_r;
            gen_burst_s = burst_r;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .LEN_BITS  (LEN_BITS),
        .SIZE_BITS (SIZE_BITS)
    ) u_addr_gen (
        .addr      (gen_addr_s),
        .len       (gen_len_s),
        .size      (gen_size_s),
        .burst     (gen_burst_s),
        .next_addr (next_addr_s),
        .illegal   (illegal_s)
    );

`ifdef AXI_SLV_WR_STALL_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    assign lfsr_nxt_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    // w_ready is registered, so the next LFSR value is what shows up in DATA.
    assign stall_ok_s = lfsr_nxt_s[0];

    // Free-running back-pressure LFSR.
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end
`else
    assign stall_ok_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic: a burst ends on its counted last beat or an early w_last.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (aw_hs_s) begin
                    next_state_s = DATA;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DATA: begin
                if (w_hs_s && (last_cnt_s || w_last)) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = DATA;
                end
            end
            RESP: begin
                if (b_hs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Sticky error: seeded by the capture check, then accumulates per-beat faults
    // (out-of-range word, w_last disagreeing with the beat count).
    always_comb begin
        err_nxt_s = err_r;
        if (aw_hs_s) begin
            err_nxt_s = illegal_s;
        end else if (w_hs_s) begin
            err_nxt_s = err_r | oob_s | (last_cnt_s ^ w_last);
        end else begin
            err_nxt_s = err_r;
        end
    end

    // FSM output logic, computed for the upcoming state so outputs can be registered.
    always_comb begin
        aw_ready_nxt_s = 1'b0;
        w_ready_nxt_s  = 1'b0;
        b_valid_nxt_s  = 1'b0;
        b_resp_nxt_s   = OKAY;
        case (next_state_s)
            IDLE: begin
                aw_ready_nxt_s = 1'b1;
            end
            DATA: begin
                w_ready_nxt_s = stall_ok_s;
            end
            RESP: begin
                b_valid_nxt_s = 1'b1;
                b_resp_nxt_s  = err_nxt_s ? SLVERR : OKAY;
            end
            default: begin
                aw_ready_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake and response outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            b_resp_r   <= OKAY;
        end else begin
            aw_ready_r <= aw_ready_nxt_s;
            w_ready_r  <= w_ready_nxt_s;
            b_valid_r  <= b_valid_nxt_s;
            b_resp_r   <= b_resp_nxt_s;
        end
    end

    // Burst capture, beat counting and address walking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_r     <= {ADDR_BITS{1'b0}};
            len_r      <= {LEN_BITS{1'b0}};
            size_r     <= {SIZE_BITS{1'b0}};
            burst_r    <= 2'b00;
            beat_cnt_r <= {LEN_BITS{1'b0}};
            err_r      <= 1'b0;
            cap_err_r  <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
            if (aw_hs_s) begin
                addr_r     <= aw_addr;
                len_r      <= aw_len;
                size_r     <= aw_size;
                burst_r    <= aw_burst;
                beat_cnt_r <= {LEN_BITS{1'b0}};
                cap_err_r  <= illegal_s;
            end else if (w_hs_s) begin
                addr_r     <= next_addr_s;
                beat_cnt_r <= beat_cnt_r + {{(LEN_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Byte-lane memory writes; contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int i = 0; i < STRB_BITS; i++) begin
                if (w_strb[i]) begin
                    mem_r[idx_s][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    // Debug read port: registered, so a same-cycle write shows the old word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            dbg_rdata_r <= {DATA_BITS{1'b0}};
        end else begin
            dbg_rdata_r <= mem_r[dbg_addr];
        end
    end

    assign aw_ready  = aw_ready_r;
    assign w_ready   = w_ready_r;
    assign b_valid   = b_valid_r;
    assign b_resp    = b_resp_r;
    assign dbg_rdata = dbg_rdata_r;

endmodule
